// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared addresses, character codes, entry and drain-state types for the display queue
package display_pkg;

  localparam logic [15:0] DEF_DSR_ADDR = 16'hFE04;
  localparam logic [15:0] DEF_DDR_ADDR = 16'hFE06;
  localparam logic [15:0] DEF_DCR_ADDR = 16'hFE08;

  localparam logic [7:0] CHAR_BS = 8'h08;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  typedef struct packed {
    logic        IsAddr;
    logic [11:0] Payload;
  } tx_entry_t;

  typedef enum logic [1:0] {IDLE, GAP1, GAP2} drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with full/empty flags
module sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_N,
  input  logic             WrEn,
  input  logic [WIDTH-1:0] WrData,
  input  logic             RdEn,
  output logic [WIDTH-1:0] RdData,
  output logic             Full,
  output logic             Empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign Full   = (count == (AW+1)'(DEPTH));
  assign Empty  = (count == '0);
  assign push   = WrEn && !Full;
  assign pop    = RdEn && !Empty;
  assign RdData = mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wrPtr] <= WrData;
  end

endmodule

// File: rtl/display_tx_queue.sv
// rtl/display_tx_queue.sv - DSR/DDR/DCR console port draining a command FIFO into the display driver (option: DISPLAY_TX_CR_FILTER_EN)
module display_tx_queue
  import display_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [15:0] DSR_ADDR = DEF_DSR_ADDR,
  parameter logic [15:0] DDR_ADDR = DEF_DDR_ADDR,
  parameter logic [15:0] DCR_ADDR = DEF_DCR_ADDR
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic [15:0] BusAddr,
  input  logic [15:0] BusDataIn,
  input  logic        BusWE,
  output logic [15:0] BusDataOut,
  output logic        Irq,
  input  logic        Ready,
  output logic        CharWE,
  output logic [7:0]  CharIn,
  output logic        AddressWE,
  output logic [11:0] AddressIn
);

  logic         ie;
  logic         ovf;
  logic [7:0]   lastChar;
  logic [11:0]  lastAddr;
  logic         fifoFull;
  logic         fifoEmpty;
  logic         pushReq;
  logic         popReq;
  logic         crDrop;
  logic         dsrWr;
  logic         ddrWr;
  logic         dcrWr;
  logic         unusedBus;
  tx_entry_t    pushEntry;
  tx_entry_t    head;
  drain_state_t state;
  drain_state_t nextState;

  assign dsrWr     = BusWE && (BusAddr == DSR_ADDR);
  assign ddrWr     = BusWE && (BusAddr == DDR_ADDR);
  assign dcrWr     = BusWE && (BusAddr == DCR_ADDR);
  assign unusedBus = ^{BusDataIn[15], BusDataIn[12]};

`ifdef DISPLAY_TX_CR_FILTER_EN
  assign crDrop = ddrWr && (BusDataIn[7:0] == CHAR_CR);
`else
  assign crDrop = 1'b0;
`endif

  assign pushReq   = (ddrWr && !crDrop) || dcrWr;
  assign pushEntry = dcrWr ? tx_entry_t'{IsAddr: 1'b1, Payload: BusDataIn[11:0]}
                           : tx_entry_t'{IsAddr: 1'b0, Payload: {4'h0, BusDataIn[7:0]}};

  sync_fifo #(
    .WIDTH ($bits(tx_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .WrEn    (pushReq),
    .WrData  (pushEntry),
    .RdEn    (popReq),
    .RdData  (head),
    .Full    (fifoFull),
    .Empty   (fifoEmpty)
  );

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      ie       <= 1'b0;
      ovf      <= 1'b0;
      lastChar <= '0;
      lastAddr <= '0;
    end else begin
      if (dsrWr) begin
        ie <= BusDataIn[14];
        if (BusDataIn[13]) ovf <= 1'b0;
      end
      // Full is judged before this edge's pop, so a simultaneous drain never saves the write.
      if (pushReq && fifoFull) ovf <= 1'b1;
      if (ddrWr && !crDrop && !fifoFull) lastChar <= BusDataIn[7:0];
      if (dcrWr && !fifoFull) lastAddr <= BusDataIn[11:0];
    end
  end

  always_comb begin
    BusDataOut = 16'h0000;
    if (BusAddr == DSR_ADDR)
      BusDataOut = {!fifoFull, ie, ovf, fifoEmpty && (state == IDLE), 12'h000};
    else if (BusAddr == DDR_ADDR)
      BusDataOut = {8'h00, lastChar};
    else if (BusAddr == DCR_ADDR)
      BusDataOut = {4'h0, lastAddr};
  end

  assign Irq = ie && !fifoFull;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) state <= IDLE;
    else          state <= nextState;
  end

  // Two gap cycles let the driver drop Ready before it is sampled again.
  always_comb begin
    nextState = state;
    popReq    = 1'b0;
    CharWE    = 1'b0;
    CharIn    = '0;
    AddressWE = 1'b0;
    AddressIn = '0;
    case (state)
      IDLE: begin
        if (!fifoEmpty && Ready) begin
          popReq    = 1'b1;
          nextState = GAP1;
          if (head.IsAddr) begin
            AddressWE = 1'b1;
            AddressIn = head.Payload;
          end else begin
            CharWE = 1'b1;
            CharIn = head.Payload[7:0];
          end
        end
      end
      GAP1:    nextState = GAP2;
      GAP2:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

endmodule
